// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: forwarding-select codes, the
// hazard controller FSM state type and the default register-index width.
package core_pkg;

    localparam int REG_ADDR_W_DEF = 4;

    // EXE operand sources
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Hazard controller FSM: normal flow or waiting on data memory
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one EXE source. The newest producer (MEM)
// wins over the older one (WB); a producer only counts when it writes back.
import core_pkg::*;

module forwarding_unit #(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    output logic [1:0]            sel
);

    // Priority compare: MEM result first, then WB value, else register file
    always_comb begin
        sel = FWD_RF;
        if (mem_wb_en && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_wb_en && (wb_dest == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline.
// Optional feature macro: FORWARDING_EN. When defined, EXE operands are
// forwarded from MEM/WB and only load-use raises a bubble; when undefined,
// any ID source matching an in-flight EXE/MEM destination stalls and the
// forwarding selects are tied to the register file.
import core_pkg::*;

module pipeline_hazard_controller #(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_src1,
    input  logic [REG_ADDR_W-1:0] exe_src2,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  exe_wb_en,
    input  logic                  mem_wb_en,
    input  logic                  wb_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idexe_hold,
    output logic                  idexe_flush,
    output logic                  exemem_hold,
    output logic                  memwb_hold,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  mem_timeout_err,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    hz_state_t        state;
    hz_state_t        state_next;
    logic [CNT_W-1:0] wait_cnt;
    // Set for the one cycle after an abandoned access so the still-pending
    // request cannot immediately re-freeze the pipe.
    logic             abandon;
    logic             freeze;
    logic             timeout_hit;
    logic             hazard;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    // Freeze detection and the timeout strobe for the current wait cycle
    always_comb begin
        timeout_hit = 1'b0;
        freeze      = 1'b0;
        if (state == ST_MEM_WAIT) begin
            freeze      = !mem_ready;
            timeout_hit = !mem_ready && ((wait_cnt + CNT_W'(1)) == TIMEOUT_VAL);
        end else begin
            freeze      = mem_req && !mem_ready && !abandon;
            timeout_hit = 1'b0;
        end
    end

    // Data-hazard detection between the ID sources and in-flight producers
    always_comb begin
        hazard = 1'b0;
`ifdef FORWARDING_EN
        if (exe_mem_r_en && exe_wb_en &&
            ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)))) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
`else
        if (exe_wb_en &&
            ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)))) begin
            hazard = 1'b1;
        end else if (mem_wb_en &&
            ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)))) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
`endif
    end

    // Pipeline controls: freeze beats branch, branch beats data hazard
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idexe_hold  = 1'b0;
        idexe_flush = 1'b0;
        exemem_hold = 1'b0;
        memwb_hold  = 1'b0;
        if (freeze) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_hold  = 1'b1;
            exemem_hold = 1'b1;
            memwb_hold  = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_flush = 1'b1;
        end else begin
            pc_hold     = 1'b0;
        end
    end

    // FSM next-state: enter the wait on an unanswered request, leave on
    // ready or when the wait budget is used up
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready && !abandon) begin
                    state_next = ST_MEM_WAIT;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || timeout_hit) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_MEM_WAIT;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter: held at zero outside the wait, counts each wait cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_MEM_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Abandon marker and sticky timeout error
    always_ff @(posedge clk) begin
        if (rst) begin
            abandon         <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            abandon         <= timeout_hit;
            mem_timeout_err <= mem_timeout_err | timeout_hit;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_hold && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src       (exe_src1),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_a_raw)
    );

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src       (exe_src2),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_b_raw)
    );

`ifdef FORWARDING_EN
    assign fwd_sel_a = fwd_a_raw;
    assign fwd_sel_b = fwd_b_raw;
`else
    // Without forwarding the EXE operands always come from the register file
    assign fwd_sel_a = FWD_RF;
    assign fwd_sel_b = FWD_RF;
    logic unused_nofwd;
    assign unused_nofwd = ^{fwd_a_raw, fwd_b_raw, exe_mem_r_en};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (builds with or without
// FORWARDING_EN). A behavioural model derived from the pipeline rules is
// compared against the DUT every cycle; directed scenarios add literal checks.
module tb_pipeline_hazard_controller;

    localparam int RW   = 4;
    localparam int TO   = 4;
    localparam int PW   = 4;
    localparam int SMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_src1, id_src2, exe_src1, exe_src2;
    logic [RW-1:0] exe_dest, mem_dest, wb_dest;
    logic          id_two_src, exe_wb_en, mem_wb_en, wb_wb_en;
    logic          exe_mem_r_en, mem_req, mem_ready, branch_taken;
    logic          pc_hold, ifid_hold, ifid_flush, idexe_hold, idexe_flush;
    logic          exemem_hold, memwb_hold, mem_timeout_err;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic [PW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idexe_hold(idexe_hold), .idexe_flush(idexe_flush),
        .exemem_hold(exemem_hold), .memwb_hold(memwb_hold),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid  = 1'b0;
    int m_frozen = 0;     // consecutive frozen cycles of the current access
    bit m_err    = 1'b0;
    bit m_aband  = 1'b0;  // previous cycle abandoned an access
    int m_stalls = 0;
    bit e_frz    = 1'b0;
    bit e_pc     = 1'b0;

    function automatic bit reads(input logic [RW-1:0] d);
        return (d == id_src1) || (id_two_src && (d == id_src2));
    endfunction

    function automatic logic [1:0] fwd_of(input logic [RW-1:0] s);
`ifdef FORWARDING_EN
        if (mem_wb_en && mem_dest == s) return 2'd1;
        if (wb_wb_en && wb_dest == s) return 2'd2;
        return 2'd0;
`else
        return 2'd0;
`endif
    endfunction

    // Compare process: expectations from current inputs and model state
    always @(negedge clk) begin
        automatic bit frz, haz;
        automatic logic [6:0] ctl;
        frz = (m_frozen > 0) ? !mem_ready : (mem_req && !mem_ready && !m_aband);
`ifdef FORWARDING_EN
        haz = exe_mem_r_en && exe_wb_en && reads(exe_dest);
`else
        haz = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
`endif
        // {pc, ifid_hold, ifid_flush, idexe_hold, idexe_flush, exemem_hold, memwb_hold}
        if (frz)               ctl = 7'b1101011;
        else if (branch_taken) ctl = 7'b0010100;
        else if (haz)          ctl = 7'b1100100;
        else                   ctl = 7'b0000000;
        e_frz <= frz;
        e_pc  <= ctl[6];
        if (m_valid) begin
            check("model_ctrl", {pc_hold, ifid_hold, ifid_flush, idexe_hold,
                                 idexe_flush, exemem_hold, memwb_hold}, ctl);
            check("model_fwd", {fwd_sel_a, fwd_sel_b}, {fwd_of(exe_src1), fwd_of(exe_src2)});
            check("model_status", {mem_timeout_err, stall_cycles}, {m_err, PW'(m_stalls)});
        end
    end

    // Model state advance at the active edge
    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_frozen <= 0;
            m_err    <= 1'b0;
            m_aband  <= 1'b0;
            m_stalls <= 0;
        end else begin
            m_stalls <= (e_pc && m_stalls < SMAX) ? m_stalls + 1 : m_stalls;
            if (e_frz && (m_frozen + 1 == TO + 1)) begin
                m_frozen <= 0;
                m_err    <= 1'b1;
                m_aband  <= 1'b1;
            end else begin
                m_frozen <= e_frz ? m_frozen + 1 : 0;
                m_aband  <= 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        exe_src1 = '0; exe_src2 = '0;
        exe_dest = '0; mem_dest = '0; wb_dest = '0;
        exe_wb_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
        exe_mem_r_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_pc_hold", pc_hold, 0);
        check("reset_flush", {ifid_flush, idexe_flush}, 0);
        check("reset_stall", stall_cycles, 0);
        check("reset_err", mem_timeout_err, 0);
        tick();

        // Load-use: LDR r3 in EXE, ADD r3 in ID
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        id_src1 = 4'd3; id_src2 = 4'd5; id_two_src = 1'b1;
        @(negedge clk);
        check("loaduse_bubble", {pc_hold, ifid_hold, idexe_flush}, 3'b111);
        tick();
        // Load now in MEM, ADD in EXE reading r3
        exe_mem_r_en = 1'b0; exe_dest = 4'd4; exe_src1 = 4'd3;
        mem_dest = 4'd3; mem_wb_en = 1'b1; id_src1 = 4'd6; id_src2 = 4'd7;
        @(negedge clk);
        check("loaduse_release", pc_hold, 0);
`ifdef FORWARDING_EN
        check("loaduse_fwd_a", fwd_sel_a, 1);
`else
        check("loaduse_fwd_a", fwd_sel_a, 0);
`endif
        tick();

        // ALU chain: MEM and WB both write r2, EXE and ID read r2
        idle();
        mem_dest = 4'd2; mem_wb_en = 1'b1; wb_dest = 4'd2; wb_wb_en = 1'b1;
        exe_src1 = 4'd2; exe_src2 = 4'd9; id_src1 = 4'd2;
        @(negedge clk);
`ifdef FORWARDING_EN
        check("chain_mem_wins", fwd_sel_a, 1);
        check("chain_no_stall", pc_hold, 0);
`else
        check("chain_fwd_off", fwd_sel_a, 0);
        check("chain_stall", {pc_hold, idexe_flush}, 2'b11);
`endif
        tick();
        mem_wb_en = 1'b0;
        @(negedge clk);
`ifdef FORWARDING_EN
        check("chain_wb_only", fwd_sel_a, 2);
`else
        check("chain_wb_only", fwd_sel_a, 0);
`endif
        check("chain_wb_nostall", pc_hold, 0);
        tick();

        // Branch beats a pending hazard
        idle();
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd1; id_src1 = 4'd1;
        branch_taken = 1'b1;
        @(negedge clk);
        check("branch_flush", {ifid_flush, idexe_flush, pc_hold}, 3'b110);
        tick();

        // Memory wait: ready low for 3 cycles
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("memwait_holds", {pc_hold, ifid_hold, idexe_hold, exemem_hold, memwb_hold}, 5'b11111);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("memwait_release", {pc_hold, memwb_hold}, 2'b00);
        tick();
        idle();
        @(negedge clk);
        check("memwait_stalls", stall_cycles, 3);
        tick();

        // Branch held while frozen, taken on release
        do_reset();
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("branch_frozen", {ifid_flush, idexe_flush, pc_hold}, 3'b001);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("branch_release", {ifid_flush, idexe_flush, ifid_hold}, 3'b110);
        tick();

        // Timeout: ready never arrives
        do_reset();
        mem_req = 1'b1;
        for (int k = 0; k < TO + 1; k++) begin
            @(negedge clk);
            check("timeout_freeze", pc_hold, 1);
            tick();
        end
        @(negedge clk);
        check("timeout_advance", pc_hold, 0);
        check("timeout_err", mem_timeout_err, 1);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk);
        check("timeout_sticky", mem_timeout_err, 1);
        tick();
        do_reset();
        @(negedge clk);
        check("timeout_rst_clear", mem_timeout_err, 0);
        tick();

        // Reset during MEM_WAIT
        mem_req = 1'b1;
        tick();
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_outputs", {pc_hold, ifid_hold, idexe_hold, exemem_hold, memwb_hold,
                                  ifid_flush, idexe_flush, fwd_sel_a, fwd_sel_b}, 0);
        check("rstwait_counters", {mem_timeout_err, stall_cycles}, 0);
        tick();

        // Stall counter saturation
        do_reset();
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd8; id_src1 = 4'd8;
        for (int k = 0; k < SMAX + 5; k++) tick();
        idle();
        @(negedge clk);
        check("stall_saturate", stall_cycles, SMAX);
        tick();

        // Mixed vectors checked by the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            id_src1 = RW'($urandom_range(0, 3)); id_src2 = RW'($urandom_range(0, 3));
            exe_src1 = RW'($urandom_range(0, 3)); exe_src2 = RW'($urandom_range(0, 3));
            exe_dest = RW'($urandom_range(0, 3)); mem_dest = RW'($urandom_range(0, 3));
            wb_dest = RW'($urandom_range(0, 3));
            id_two_src = 1'($urandom_range(0, 1)); exe_wb_en = 1'($urandom_range(0, 1));
            mem_wb_en = 1'($urandom_range(0, 1)); wb_wb_en = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1)); mem_req = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
